mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single fixed-latency memory.
// One access in flight at a time; ties alternate between ports.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        gnt_if,
  output logic        gnt_d
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_owner;     // 1 = data port
  logic        r_last;      // 1 = data port was granted last
  logic        r_wr;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_if_rdata;
  logic [15:0] r_d_rdata;
  logic        r_if_valid;
  logic        r_d_valid;

  logic        w_pick_d;
  logic        w_sample;

  assign w_pick_d = d_req & (~if_req | ~r_last);

  // mem_rdata is captured at the edge that ends the last cycle before DONE
  assign w_sample = ((r_state == S_ISSUE) && (LATENCY == 1)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_owner    <= 1'b0;
      r_last     <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      if (w_sample) begin
        if (!r_owner)
          r_if_rdata <= mem_rdata;
        else if (!r_wr)
          r_d_rdata <= mem_rdata;
      end
      case (r_state)
        S_IDLE: begin
          if (if_req || d_req) begin
            r_owner <= w_pick_d;
            r_last  <= w_pick_d;
            r_wr    <= w_pick_d & d_wr;
            r_addr  <= w_pick_d ? d_addr : if_addr;
            r_wdata <= w_pick_d ? d_wdata : '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= CNT_LOAD;
          r_state <= (LATENCY == 1) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_if_valid <= ~r_owner;
          r_d_valid  <= r_owner;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = (r_state == S_ISSUE);
  assign mem_wr    = mem_en & r_wr;
  assign mem_addr  = mem_en ? r_addr : '0;
  assign mem_wdata = mem_en ? r_wdata : '0;

  assign gnt_if = (r_state != S_IDLE) & ~r_owner;
  assign gnt_d  = (r_state != S_IDLE) & r_owner;

  assign if_rdata = r_if_rdata;
  assign if_valid = r_if_valid;
  assign d_rdata  = r_d_rdata;
  assign d_valid  = r_d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=4 main instance plus a LATENCY=1 instance.
// Completions are checked against a scoreboard of expected port/data/cycle.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req, d_req, d_wr;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, mem_en, mem_wr, gnt_if, gnt_d;

  logic        if_req1;
  logic [15:0] if_addr1, mem_rdata1;
  logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_valid1, d_valid1, mem_en1, mem_wr1, gnt_if1, gnt_d1;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  typedef struct {
    bit          port;   // 1 = data
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mem_arbiter #(.LATENCY(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt_if(gnt_if), .gnt_d(gnt_d)
  );

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_valid(if_valid1),
    .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_rdata(d_rdata1), .d_valid(d_valid1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .gnt_if(gnt_if1), .gnt_d(gnt_d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'hA5B5;
  endfunction

  // Memory models: data is only valid in the cycle (ISSUE + LATENCY - 1).
  logic [15:0] m_addr, m_addr1;
  int          m_age, m_age1;
  bit          m_busy, m_busy1;
  initial begin
    m_busy = 0; m_age = 0; m_addr = '0; mem_rdata = 16'hDEAD;
    m_busy1 = 0; m_age1 = 0; m_addr1 = '0; mem_rdata1 = 16'hDEAD;
  end
  always @(negedge clk) begin
    if (mem_en) begin
      m_busy = 1; m_age = 0; m_addr = mem_addr;
    end else if (m_busy) begin
      m_age++;
      if (m_age > 3) m_busy = 0;
    end
    mem_rdata = (m_busy && m_age == 3) ? mem_f(m_addr) : 16'hDEAD;
  end
  always @(negedge clk) begin
    if (mem_en1) begin
      m_busy1 = 1; m_age1 = 0; m_addr1 = mem_addr1;
    end else begin
      m_busy1 = 0;
    end
    mem_rdata1 = (m_busy1 && m_age1 == 0) ? mem_f(m_addr1) : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (if_valid || d_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 16'(sb.size()), 16'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_port_d", {15'b0, d_valid}, {15'b0, e.port});
        check("valid_port_if", {15'b0, if_valid}, {15'b0, ~e.port});
        check("rdata", e.port ? d_rdata : if_rdata, e.data);
        check("valid_cycle", 16'(cyc), 16'(e.cyc));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit port);
    bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((port && d_valid) || (!port && if_valid)) begin
        found = 1;
        break;
      end
    end
    check(port ? "d_valid_timeout" : "if_valid_timeout", {15'b0, found}, 16'd1);
  endtask

  task automatic push(input bit port, input logic [15:0] data, input int c);
    exp_t e;
    e.port = port; e.data = data; e.cyc = c;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    rst_n = 0; if_req = 0; if_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    if_req1 = 0; if_addr1 = '0;
    #3;
    check("rst_if_rdata", if_rdata, 16'h0);
    check("rst_d_rdata", d_rdata, 16'h0);
    check("rst_mem_en", {15'b0, mem_en}, 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_gnt", {14'b0, gnt_if, gnt_d}, 16'h0);
    check("rst_valid", {14'b0, if_valid, d_valid}, 16'h0);
    repeat (2) tick();
    rst_n = 1;
    tick();

    // Single fetch
    c0 = cyc; if_req = 1; if_addr = 16'h0010;
    push(0, 16'hA5A5, c0 + 6);
    tick();
    check("f_mem_en", {15'b0, mem_en}, 16'h1);
    check("f_mem_addr", mem_addr, 16'h0010);
    check("f_mem_wr", {15'b0, mem_wr}, 16'h0);
    check("f_gnt", {14'b0, gnt_if, gnt_d}, 16'h2);
    if_addr = 16'hFFFF;
    tick();
    check("f_mem_en_off", {15'b0, mem_en}, 16'h0);
    check("f_mem_addr_off", mem_addr, 16'h0);
    wait_valid(0);
    if_req = 0;
    tick();
    check("f_valid_pulse", {15'b0, if_valid}, 16'h0);
    check("f_idle_gnt", {14'b0, gnt_if, gnt_d}, 16'h0);
    check("f_rdata_hold", if_rdata, 16'hA5A5);

    // Data load
    c0 = cyc; d_req = 1; d_wr = 0; d_addr = 16'h0300;
    push(1, 16'hA6B5, c0 + 6);
    tick();
    check("ld_gnt", {14'b0, gnt_if, gnt_d}, 16'h1);
    check("ld_mem_addr", mem_addr, 16'h0300);
    check("ld_mem_wr", {15'b0, mem_wr}, 16'h0);
    wait_valid(1);
    d_req = 0;
    tick();

    // Data store
    c0 = cyc; d_req = 1; d_wr = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    push(1, 16'hA6B5, c0 + 6);
    tick();
    check("st_mem_en", {15'b0, mem_en}, 16'h1);
    check("st_mem_wr", {15'b0, mem_wr}, 16'h1);
    check("st_mem_addr", mem_addr, 16'h0200);
    check("st_mem_wdata", mem_wdata, 16'h1234);
    tick();
    check("st_mem_wr_off", {15'b0, mem_wr}, 16'h0);
    check("st_mem_wdata_off", mem_wdata, 16'h0);
    wait_valid(1);
    d_req = 0; d_wr = 0;
    tick();
    check("st_d_rdata_kept", d_rdata, 16'hA6B5);

    // Reset, then both ports held: D, IF, D, IF
    rst_n = 0;
    tick();
    rst_n = 1;
    c0 = cyc; if_req = 1; if_addr = 16'h0040; d_req = 1; d_addr = 16'h0080;
    push(1, 16'hA535, c0 + 6);
    push(0, 16'hA5F5, c0 + 12);
    push(1, 16'hA535, c0 + 18);
    push(0, 16'hA5F5, c0 + 24);
    for (int i = 1; i <= 24; i++) begin
      int  o;
      bit  own_d;
      tick();
      o = (i - 1) % 6;
      own_d = (((i - 1) / 6) % 2) == 0;
      check("alt_gnt_d", {15'b0, gnt_d}, {15'b0, own_d && o < 5});
      check("alt_gnt_if", {15'b0, gnt_if}, {15'b0, !own_d && o < 5});
      check("alt_mem_en", {15'b0, mem_en}, {15'b0, o == 0});
      check("alt_mem_addr", mem_addr, (o == 0) ? (own_d ? 16'h0080 : 16'h0040) : 16'h0);
    end
    if_req = 0; d_req = 0;
    tick();

    // Reset during WAIT aborts the access
    if_req = 1; if_addr = 16'h0100;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    check("abort_if_rdata", if_rdata, 16'h0);
    check("abort_d_rdata", d_rdata, 16'h0);
    check("abort_gnt", {14'b0, gnt_if, gnt_d}, 16'h0);
    check("abort_mem_en", {15'b0, mem_en}, 16'h0);
    if_req = 0;
    tick();
    tick();
    rst_n = 1;
    repeat (8) tick();
    check("abort_no_valid_rdata", if_rdata, 16'h0);
    c0 = cyc; if_req = 1; if_addr = 16'h0020;
    push(0, 16'hA595, c0 + 6);
    wait_valid(0);
    if_req = 0;
    tick();
    check("post_rst_rdata", if_rdata, 16'hA595);

    // LATENCY=1 instance: ISSUE then DONE, valid three cycles after request
    if_req1 = 1; if_addr1 = 16'h0033;
    tick();
    check("l1_mem_en", {15'b0, mem_en1}, 16'h1);
    check("l1_mem_addr", mem_addr1, 16'h0033);
    check("l1_gnt_issue", {15'b0, gnt_if1}, 16'h1);
    tick();
    check("l1_mem_en_off", {15'b0, mem_en1}, 16'h0);
    check("l1_gnt_done", {15'b0, gnt_if1}, 16'h1);
    check("l1_valid_early", {15'b0, if_valid1}, 16'h0);
    tick();
    check("l1_valid", {15'b0, if_valid1}, 16'h1);
    check("l1_rdata", if_rdata1, 16'hA586);
    check("l1_gnt_idle", {15'b0, gnt_if1}, 16'h0);
    if_req1 = 0;
    tick();
    check("l1_valid_pulse", {15'b0, if_valid1}, 16'h0);

    repeat (3) tick();
    check("sb_leftover", 16'(sb.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
